// File: rtl/acc_requant_if.sv
// Stream bundle for acc_requant: accumulator beats with per-beat requant config in,
// saturated activations out, both with valid/ready handshakes.
interface acc_requant_if #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5
) ();
    logic               in_valid;
    logic               in_ready;
    logic [ACC_W-1:0]   in_acc;
    logic [ACC_W-1:0]   in_bias;
    logic [MULT_W-1:0]  in_mult;
    logic [SHIFT_W-1:0] in_shift;
    logic               in_relu;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_sat;

    modport master (
        output in_valid, in_acc, in_bias, in_mult, in_shift, in_relu, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_acc, in_bias, in_mult, in_shift, in_relu, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/acc_requant.sv
// Requantisation stage: bias add, integer multiply, rounding right-shift, optional ReLU and
// saturation to OUT_W bits, in a 3-stage valid/ready pipeline that stalls as a whole.
module acc_requant #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    acc_requant_if.slave     bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] sat_count
);
    localparam int SUM_W  = ACC_W + 1;
    localparam int PROD_W = ACC_W + MULT_W + 2;
    localparam logic signed [PROD_W-1:0] HI_LIM = PROD_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [PROD_W-1:0] LO_LIM = -HI_LIM - 1;

    logic                      ready_reg;
    logic                      advance;
    logic                      in_ready_w;
    logic                      accept;

    logic                      s1_valid_reg;
    logic signed [SUM_W-1:0]   s1_sum_reg;
    logic [MULT_W-1:0]         s1_mult_reg;
    logic [SHIFT_W-1:0]        s1_shift_reg;
    logic                      s1_relu_reg;

    logic                      s2_valid_reg;
    logic signed [PROD_W-1:0]  s2_prod_reg;
    logic [SHIFT_W-1:0]        s2_shift_reg;
    logic                      s2_relu_reg;

    logic                      out_valid_reg;
    logic [OUT_W-1:0]          out_data_reg;
    logic                      out_sat_reg;
    logic [CNT_W-1:0]          sat_count_reg;

    logic signed [PROD_W-1:0]  sum_ext;
    logic signed [PROD_W-1:0]  mult_ext;
    logic signed [PROD_W-1:0]  half;
    logic signed [PROD_W-1:0]  rounded;
    logic [OUT_W-1:0]          data_next;
    logic                      sat_next;

    // in_ready is held low for the first cycle after reset release, then follows the stall state.
    assign advance    = ~out_valid_reg | bus.out_ready;
    assign in_ready_w = ready_reg & advance;
    assign accept     = bus.in_valid & in_ready_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sat   = out_sat_reg;
    assign sat_count     = sat_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_reg <= 1'b0;
        else        ready_reg <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sum_reg   <= '0;
            s1_mult_reg  <= '0;
            s1_shift_reg <= '0;
            s1_relu_reg  <= 1'b0;
        end else if (advance) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_sum_reg   <= $signed({bus.in_acc[ACC_W-1], bus.in_acc})
                              + $signed({bus.in_bias[ACC_W-1], bus.in_bias});
                s1_mult_reg  <= bus.in_mult;
                s1_shift_reg <= bus.in_shift;
                s1_relu_reg  <= bus.in_relu;
            end
        end
    end

    assign sum_ext  = PROD_W'(s1_sum_reg);
    assign mult_ext = $signed(PROD_W'(s1_mult_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_prod_reg  <= '0;
            s2_shift_reg <= '0;
            s2_relu_reg  <= 1'b0;
        end else if (advance) begin
            s2_valid_reg <= s1_valid_reg;
            s2_prod_reg  <= sum_ext * mult_ext;
            s2_shift_reg <= s1_shift_reg;
            s2_relu_reg  <= s1_relu_reg;
        end
    end

    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    assign half    = (s2_shift_reg == '0) ? '0 : $signed(PROD_W'(1) << (s2_shift_reg - 1'b1));
    assign rounded = (s2_prod_reg + half) >>> s2_shift_reg;

    always_comb begin
        data_next = rounded[OUT_W-1:0];
        sat_next  = 1'b0;
        if (s2_relu_reg && (rounded < 0)) begin
            data_next = '0;
        end else if (rounded > HI_LIM) begin
            data_next = {1'b0, {(OUT_W-1){1'b1}}};
            sat_next  = 1'b1;
        end else if (rounded < LO_LIM) begin
            data_next = {1'b1, {(OUT_W-1){1'b0}}};
            sat_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= s2_valid_reg;
            out_data_reg  <= data_next;
            out_sat_reg   <= sat_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_reg <= '0;
        end else if (clr_cnt) begin
            sat_count_reg <= '0;
        end else if (out_valid_reg && bus.out_ready && out_sat_reg && !(&sat_count_reg)) begin
            sat_count_reg <= sat_count_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_acc_requant.sv
// Directed bench for acc_requant: an arithmetic reference model feeds an expectation queue that one
// negedge process checks against every output handshake, plus hand-computed literal expectations.
module tb_acc_requant;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int MULT_W  = 16;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] sat_count;

    acc_requant_if #(.ACC_W(ACC_W), .OUT_W(OUT_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W)) bus ();

    acc_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_cnt(clr_cnt), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on 64-bit values, then ReLU and clamp.
    function automatic void model(input logic signed [ACC_W-1:0] acc, input logic signed [ACC_W-1:0] bias,
                                  input logic [MULT_W-1:0] mult, input logic [SHIFT_W-1:0] sh,
                                  input bit relu, output int d, output bit s);
        longint p, r;
        p = (longint'(acc) + longint'(bias)) * longint'(mult);
        r = p;
        if (sh != 0) r = (p + (longint'(1) << (sh - 1))) >>> sh;
        s = 1'b0;
        if (relu && r < 0)  d = 0;
        else if (r > 127)   begin d = 127;  s = 1'b1; end
        else if (r < -128)  begin d = -128; s = 1'b1; end
        else                d = int'(r);
    endfunction

    typedef struct {
        int d;
        bit s;
        bit has_lit;
        int lit_d;
        bit lit_s;
    } exp_t;

    exp_t q[$];
    exp_t e, np;
    int   cnt_m = 0;
    int   out_count = 0;
    int   stall_cycles = 0;
    bit   lit_valid = 1'b0;
    int   lit_d = 0;
    bit   lit_s = 1'b0;
    bit   prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data;
    logic prev_sat;
    bit   hs_sat;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cnt_m = 0;
            prev_stall = 1'b0;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_data", bus.out_data, 0);
            check("rst_out_sat", bus.out_sat, 0);
            check("rst_sat_count", sat_count, 0);
            check("rst_in_ready", bus.in_ready, 0);
        end else begin
            check("sat_count", sat_count, cnt_m);
            if (prev_stall) begin
                check("stall_hold_valid", bus.out_valid, 1);
                check("stall_hold_data", bus.out_data, prev_data);
                check("stall_hold_sat", bus.out_sat, prev_sat);
            end
            if (bus.out_valid && !bus.out_ready) begin
                stall_cycles++;
                check("stall_in_ready", bus.in_ready, 0);
            end
            hs_sat = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0d with no beat outstanding", $signed(bus.out_data));
                end else begin
                    e = q.pop_front();
                    hs_sat = e.s;
                    check("out_data", $signed(bus.out_data), e.d);
                    check("out_sat", bus.out_sat, e.s);
                    if (e.has_lit) begin
                        check("lit_data", $signed(bus.out_data), e.lit_d);
                        check("lit_sat", bus.out_sat, e.lit_s);
                    end
                end
            end
            if (clr_cnt) cnt_m = 0;
            else if (hs_sat && cnt_m != CNT_MAX) cnt_m++;
            if (bus.in_valid && bus.in_ready) begin
                model(bus.in_acc, bus.in_bias, bus.in_mult, bus.in_shift, bus.in_relu, np.d, np.s);
                np.has_lit = lit_valid;
                np.lit_d   = lit_d;
                np.lit_s   = lit_s;
                q.push_back(np);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_sat   = bus.out_sat;
        end
    end

    // Called and returns at posedge+1; the beat is accepted on the posedge just before return.
    task automatic send(input logic signed [ACC_W-1:0] acc, input logic signed [ACC_W-1:0] bias,
                        input int mult, input int sh, input bit relu,
                        input bit has_lit, input int ld, input bit ls);
        bus.in_acc   = acc;
        bus.in_bias  = bias;
        bus.in_mult  = MULT_W'(mult);
        bus.in_shift = SHIFT_W'(sh);
        bus.in_relu  = relu;
        lit_valid    = has_lit;
        lit_d        = ld;
        lit_s        = ls;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                lit_valid    = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        bus.in_valid = 1'b0;
        lit_valid    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !bus.out_valid) break;
        end
        check("drain_empty", q.size(), 0);
    endtask

    task automatic lat_check(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n = i;
                break;
            end
        end
        check(name, n, 3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.in_acc    = '0;
        bus.in_bias   = '0;
        bus.in_mult   = '0;
        bus.in_shift  = '0;
        bus.in_relu   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_release", bus.in_ready, 1);

        // T1: basic bias add and pass-through, 3-cycle latency
        send(100, -3, 1, 0, 0, 1, 97, 0);
        lat_check("t1_latency");
        drain();

        // T2: rounding half toward +inf
        send(5,  0, 3, 2, 0, 1, 4,  0);
        send(-5, 0, 3, 2, 0, 1, -4, 0);
        send(-2, 0, 1, 2, 0, 1, 0,  0);
        send(6,  0, 1, 2, 0, 1, 2,  0);
        drain();

        // T3: saturation without wrap, ReLU zeroing not counted
        send(32'sh7FFFFFFF, 1, 1, 0, 0, 1, 127,  1);
        send(-1000,         0, 1, 0, 0, 1, -128, 1);
        send(-1000,         0, 1, 0, 1, 1, 0,    0);
        drain();
        @(negedge clk);
        check("t3_sat_count", sat_count, 2);
        @(posedge clk);
        #1;

        // T4: 8-beat stream with a 5-cycle output stall
        base = out_count;
        stall_cycles = 0;
        fork
            for (int i = 0; i < 8; i++)
                send(i * 37 - 100, i, i + 1, i % 4, i[0], 0, 0, 0);
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("t4_out_count", out_count - base, 8);
        check("t4_stall_cycles", stall_cycles, 5);

        // T5: reset with 3 beats in flight
        send(10, 0, 1, 0, 0, 0, 0, 0);
        send(20, 0, 1, 0, 0, 0, 0, 0);
        send(30, 0, 1, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("t5_async_out_valid", bus.out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_first_cycle", bus.in_ready, 0);
        repeat (4) begin
            @(negedge clk);
            check("t5_no_stale", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(-7, 2, 2, 1, 0, 1, -5, 0);
        lat_check("t5_latency");
        drain();

        // T6: counter saturates at all-ones, then clear beats a coincident increment
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        for (int i = 0; i < CNT_MAX + 5; i++)
            send(1000, 0, 1, 0, 0, 0, 0, 0);
        drain();
        @(negedge clk);
        check("t6_count_held", sat_count, CNT_MAX);
        @(posedge clk);
        #1;
        send(1000, 0, 1, 0, 0, 1, 127, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        check("t6_clr_wins", sat_count, 0);
        drain();

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
